// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one single-precision multiplier among N_REQ requesters.
// One operation in flight; each result is routed back to the requester that issued it.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for any req_valid; arbitrates and captures operands
// ST_SEND_A  | mul_a_stb high until mul_a_ack
// ST_SEND_B  | mul_b_stb high until mul_b_ack
// ST_WAIT_Z  | mul_z_ack high until mul_z_stb; latches the product
// ST_DELIVER | rsp_valid[grant] high until rsp_ack[grant]
module fp_mul_arbiter #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic                 iClk,
  input  logic                 iRstn,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*32-1:0]  req_a,
  input  logic [N_REQ*32-1:0]  req_b,
  output logic [N_REQ-1:0]     req_accept,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [31:0]          rsp_data,
  input  logic [N_REQ-1:0]     rsp_ack,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  output logic                 mul_a_stb,
  output logic                 mul_b_stb,
  input  logic                 mul_a_ack,
  input  logic                 mul_b_ack,
  input  logic [31:0]          mul_z,
  input  logic                 mul_z_stb,
  output logic                 mul_z_ack,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  localparam int IDX_W = $clog2(N_REQ);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND_A  = 3'd1;
  localparam logic [2:0] ST_SEND_B  = 3'd2;
  localparam logic [2:0] ST_WAIT_Z  = 3'd3;
  localparam logic [2:0] ST_DELIVER = 3'd4;

  logic [2:0]       state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant;
  logic [N_REQ-1:0] grant_oh;
  logic [N_REQ-1:0] accept_q;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [31:0]      result;

  logic             found;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] win_idx;
  logic [N_REQ-1:0] win_oh;
  logic [31:0]      win_a;
  logic [31:0]      win_b;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    found   = 1'b0;
    rr_idx  = '0;
    win_idx = '0;
    win_oh  = '0;
    win_a   = '0;
    win_b   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_idx = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (!found && req_valid[rr_idx]) begin
        found          = 1'b1;
        win_idx        = rr_idx;
        win_oh         = '0;
        win_oh[rr_idx] = 1'b1;
        win_a          = req_a[32*rr_idx +: 32];
        win_b          = req_b[32*rr_idx +: 32];
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(N_REQ - 1);
      grant      <= '0;
      grant_oh   <= '0;
      accept_q   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      result     <= '0;
      op_count   <= '0;
    end else begin
      accept_q <= '0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            op_a     <= win_a;
            op_b     <= win_b;
            grant    <= win_idx;
            grant_oh <= win_oh;
            accept_q <= win_oh;
            state    <= ST_SEND_A;
          end
        end
        ST_SEND_A: if (mul_a_ack) state <= ST_SEND_B;
        ST_SEND_B: if (mul_b_ack) state <= ST_WAIT_Z;
        ST_WAIT_Z: begin
          if (mul_z_stb) begin
            result <= mul_z;
            state  <= ST_DELIVER;
          end
        end
        ST_DELIVER: begin
          if (|(rsp_ack & grant_oh)) begin
            op_count   <= op_count + CNT_W'(1);
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Accept is registered, so it shows in the first SEND_A cycle with no path from req_valid.
  assign req_accept = accept_q;
  assign rsp_valid  = (state == ST_DELIVER) ? grant_oh : '0;
  assign rsp_data   = result;
  assign mul_a      = op_a;
  assign mul_b      = op_b;
  assign mul_a_stb  = (state == ST_SEND_A);
  assign mul_b_stb  = (state == ST_SEND_B);
  assign mul_z_ack  = (state == ST_WAIT_Z);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: four requesters, a stalling multiplier stand-in,
// and a transaction-level model of grants, responses and the completed-operation count.
module tb_fp_mul_arbiter;

  logic          clk = 1'b0;
  logic          rstn;
  logic [3:0]    req_valid;
  logic [127:0]  req_a;
  logic [127:0]  req_b;
  logic [3:0]    req_accept;
  logic [3:0]    rsp_valid;
  logic [31:0]   rsp_data;
  logic [3:0]    rsp_ack;
  logic [31:0]   mul_a;
  logic [31:0]   mul_b;
  logic          mul_a_stb;
  logic          mul_b_stb;
  logic          mul_a_ack;
  logic          mul_b_ack;
  logic [31:0]   mul_z;
  logic          mul_z_stb;
  logic          mul_z_ack;
  logic          busy;
  logic [3:0]    op_count;

  fp_mul_arbiter #(.N_REQ(4), .CNT_W(4)) dut (
    .iClk(clk), .iRstn(rstn),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_accept(req_accept),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
    .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
    .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack), .mul_z(mul_z), .mul_z_stb(mul_z_stb),
    .mul_z_ack(mul_z_ack), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  bit inflight, resp_ready, completing, z_fired, use_dir, noise_en, expect_accept;
  int owner, rr_last, ops_done, gen_div;
  int ack_wait, ack_dly, a_dly, b_dly, z_dly, a_wait, b_wait, z_wait, a_run, z_run;
  int dir_a, dir_b, dir_z, dir_ack;
  logic [31:0] exp_a, exp_b, exp_z, cap_a, cap_b, last_rsp;
  logic [31:0] qa [4];
  logic [31:0] qb [4];
  int remaining [4];
  int grant_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stand-in multiplier: exact for the directed 1.5 x 2.0 case, a scramble otherwise so
  // misrouted operands or results show up as wrong data.
  function automatic logic [31:0] mul_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0001;
  endfunction

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++)
      if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = qa[i];
      req_b[32*i +: 32] = qb[i];
    end
  endtask

  task automatic post(input int i, input logic [31:0] a, input logic [31:0] b);
    qa[i] = a;
    qb[i] = b;
    req_valid[i] = 1'b1;
    drive_ops();
    expect_accept = !inflight;
  endtask

  task automatic step();
    int w, obs_w;
    logic [31:0] eg;
    logic [3:0] erv, noise, obit;
    @(negedge clk);
    if (completing) begin
      completing = 0; inflight = 0; resp_ready = 0; rr_last = owner; ops_done++;
    end
    if (z_fired) begin
      z_fired = 0; resp_ready = 1;
    end

    chk("accept_timing", 32'(req_accept != 4'b0), 32'(expect_accept));
    if (req_accept != 4'b0) begin
      w  = rr_pick(req_valid, rr_last);
      eg = (w < 0) ? 32'd0 : (32'd1 << w);
      chk("grant", 32'(req_accept), eg);
      obs_w = 0;
      for (int i = 3; i >= 0; i--) if (req_accept[i]) obs_w = i;
      grant_log.push_back(obs_w);
      owner = obs_w; exp_a = qa[obs_w]; exp_b = qb[obs_w];
      exp_z = mul_fn(exp_a, exp_b); inflight = 1;
      req_valid[obs_w] = 1'b0;
      if (use_dir) begin
        a_dly = dir_a; b_dly = dir_b; z_dly = dir_z; ack_dly = dir_ack; use_dir = 0;
      end else begin
        a_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
        z_dly = $urandom_range(0, 5); ack_dly = $urandom_range(0, 4);
      end
    end

    chk("busy", 32'(busy), 32'(inflight));
    erv = resp_ready ? 4'(1 << owner) : 4'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'(erv));
    if (resp_ready) begin
      chk("rsp_data", rsp_data, exp_z);
      last_rsp = rsp_data;
    end
    chk("op_count", 32'(op_count), 32'(ops_done % 16));
    if (mul_a_stb) chk("mul_a", mul_a, exp_a);
    if (mul_b_stb) chk("mul_b", mul_b, exp_b);

    if (mul_a_stb) a_run++;
    else if (a_run != 0) begin chk("a_stb_len", a_run, a_dly + 1); a_run = 0; end
    if (mul_z_ack) z_run++;
    else if (z_run != 0) begin chk("z_ack_len", z_run, z_dly + 1); z_run = 0; end

    // multiplier side
    if (mul_a_stb) begin
      if (a_wait == a_dly) begin mul_a_ack = 1'b1; cap_a = mul_a; a_wait = 0; end
      else begin mul_a_ack = 1'b0; a_wait++; end
    end else begin mul_a_ack = 1'b0; a_wait = 0; end
    if (mul_b_stb) begin
      if (b_wait == b_dly) begin mul_b_ack = 1'b1; cap_b = mul_b; b_wait = 0; end
      else begin mul_b_ack = 1'b0; b_wait++; end
    end else begin mul_b_ack = 1'b0; b_wait = 0; end
    mul_z_stb = 1'b0;
    mul_z = $urandom;
    if (mul_z_ack) begin
      if (z_wait == z_dly) begin
        mul_z_stb = 1'b1; mul_z = mul_fn(cap_a, cap_b); z_fired = 1; z_wait = 0;
      end else z_wait++;
    end else z_wait = 0;

    // requester side: response ack with unrelated noise bits
    noise = noise_en ? 4'($urandom) : 4'b0;
    obit  = 4'(1 << owner);
    if (resp_ready) begin
      if (ack_wait >= ack_dly) completing = 1;
      else ack_wait++;
      rsp_ack = (noise & ~obit) | (completing ? obit : 4'b0);
    end else begin
      ack_wait = 0;
      rsp_ack  = noise;
    end

    for (int i = 0; i < 4; i++)
      if (!req_valid[i] && remaining[i] > 0 && $urandom_range(0, gen_div) == 0) begin
        remaining[i]--;
        post(i, $urandom, $urandom);
      end
    expect_accept = !inflight && (req_valid != 4'b0);
  endtask

  task automatic do_reset();
    rstn = 1'b0; req_valid = 4'b0; rsp_ack = 4'b0;
    mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z_stb = 1'b0;
    @(negedge clk);
    chk("rst_accept", 32'(req_accept), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_strobes", {29'd0, mul_a_stb, mul_b_stb, mul_z_ack}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_count", 32'(op_count), 0);
    chk("rst_operands", mul_a | mul_b, 0);
    inflight = 0; resp_ready = 0; completing = 0; z_fired = 0; use_dir = 0;
    rr_last = 3; ops_done = 0; expect_accept = 0;
    a_wait = 0; b_wait = 0; z_wait = 0; a_run = 0; z_run = 0; ack_wait = 0;
    for (int i = 0; i < 4; i++) remaining[i] = 0;
    rstn = 1'b1;
  endtask

  task automatic run_until(input int target);
    for (int c = 0; c < 4000 && ops_done < target; c++) step();
    chk("ops_done", ops_done, target);
  endtask

  task automatic set_dir(input int a, input int b, input int z, input int ack);
    dir_a = a; dir_b = b; dir_z = z; dir_ack = ack; use_dir = 1;
  endtask

  initial begin
    logic [31:0] sa, sb;
    int base;
    rstn = 1'b0; req_valid = 4'b0; req_a = '0; req_b = '0; rsp_ack = 4'b0;
    mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z = '0; mul_z_stb = 1'b0;
    for (int i = 0; i < 4; i++) begin qa[i] = '0; qb[i] = '0; remaining[i] = 0; end
    gen_div = 3; noise_en = 0; owner = 0;
    a_dly = 0; b_dly = 0; z_dly = 0; ack_dly = 0;

    // single request, 2-cycle multiplier latency
    do_reset();
    set_dir(0, 0, 1, 0);
    post(1, 32'h3FC0_0000, 32'h4000_0000);
    run_until(1);
    chk("t1_grant", grant_log[grant_log.size()-1], 1);
    chk("t1_result", last_rsp, 32'h4040_0000);
    chk("t1_count", 32'(op_count), 1);

    // contention: all four held after reset
    do_reset();
    noise_en = 1; gen_div = 0;
    base = grant_log.size();
    for (int i = 0; i < 4; i++) begin remaining[i] = 1; post(i, $urandom, $urandom); end
    run_until(8);
    for (int k = 0; k < 8; k++) chk("rr_order", grant_log[base + k], k % 4);

    // response backpressure, with requester 0 waiting behind it
    set_dir(0, 0, 1, 10);
    post(2, $urandom, $urandom);
    step(); step();
    post(0, $urandom, $urandom);
    run_until(10);
    chk("bp_order", grant_log[grant_log.size()-2] * 4 + grant_log[grant_log.size()-1], 8);

    // multiplier stalls
    sa = 32'h4120_0000; sb = 32'hC0A0_0000;
    set_dir(2, 0, 7, 0);
    post(1, sa, sb);
    run_until(11);
    chk("stall_result", last_rsp, mul_fn(sa, sb));

    // random traffic through the 4-bit counter wrap
    gen_div = 3;
    for (int i = 0; i < 4; i++) remaining[i] = 12;
    run_until(17);
    chk("wrap", 32'(op_count), 1);
    run_until(40);

    // reset in WAIT_Z
    for (int i = 0; i < 4; i++) remaining[i] = 0;
    for (int c = 0; c < 2000 && (inflight || req_valid != 4'b0); c++) step();
    chk("quiesce", 32'(inflight || req_valid != 4'b0), 0);
    set_dir(0, 0, 30, 0);
    post(1, $urandom, $urandom);
    for (int c = 0; c < 200 && z_run < 3; c++) step();
    chk("reach_wait_z", z_run, 3);
    do_reset();
    post(3, $urandom, $urandom);
    post(0, $urandom, $urandom);
    step();
    chk("post_reset_grant", 32'(req_accept), 32'h1);
    run_until(2);
    chk("post_reset_next", grant_log[grant_log.size()-1], 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
